// File: rtl/array_lane_write_sched.sv
// Word array with whole-word or lane writes, each committed after 0..MAX_DLY clocks.
// Delayed writes wait in an age-ordered queue and never show on rd_data until they commit.
module array_lane_write_sched #(
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 8,
    parameter int LANE_W  = 4,
    parameter int MAX_DLY = 15,
    parameter int QDEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [$clog2(DEPTH)-1:0]           wr_word,
    input  logic [$clog2(WORD_W/LANE_W)-1:0]   wr_lane,
    input  logic                               wr_full,
    input  logic [WORD_W-1:0]                  wr_data,
    input  logic [$clog2(MAX_DLY+1)-1:0]       wr_delay,
    input  logic [$clog2(DEPTH)-1:0]           rd_word,
    output logic [WORD_W-1:0]                  rd_data,
    output logic [$clog2(QDEPTH+1)-1:0]        pending,
    output logic                               wr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(WORD_W / LANE_W);
    localparam int DW = $clog2(MAX_DLY + 1);
    localparam int PW = $clog2(QDEPTH + 1);

    logic [WORD_W-1:0] mem     [DEPTH];
    logic [WORD_W-1:0] mem_nxt [DEPTH];

    logic              q_vld      [QDEPTH];
    logic [DW-1:0]     q_cnt      [QDEPTH];
    logic [AW-1:0]     q_word     [QDEPTH];
    logic [LW-1:0]     q_lane     [QDEPTH];
    logic              q_full     [QDEPTH];
    logic [WORD_W-1:0] q_data     [QDEPTH];
    logic              q_vld_nxt  [QDEPTH];
    logic [DW-1:0]     q_cnt_nxt  [QDEPTH];
    logic [AW-1:0]     q_word_nxt [QDEPTH];
    logic [LW-1:0]     q_lane_nxt [QDEPTH];
    logic              q_full_nxt [QDEPTH];
    logic [WORD_W-1:0] q_data_nxt [QDEPTH];

    logic [PW-1:0] occ;
    logic          accept;
    logic          drop;

    function automatic logic [WORD_W-1:0] merge(
        input logic [WORD_W-1:0] old,
        input logic              full,
        input logic [LW-1:0]     lane,
        input logic [WORD_W-1:0] data
    );
        logic [WORD_W-1:0] r;
        r = old;
        if (full)
            r = data;
        else
            r[lane*LANE_W +: LANE_W] = data[LANE_W-1:0];
        return r;
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < QDEPTH; i++)
            if (q_vld[i]) occ = occ + PW'(1);
    end

    assign wr_ready = (occ < PW'(QDEPTH));
    assign pending  = occ;
    assign accept   = wr_valid && wr_ready;
    assign drop     = accept && (({1'b0, wr_word} >= (AW+1)'(DEPTH)) ||
                                 ({1'b0, wr_delay} > (DW+1)'(MAX_DLY)));

    // Matured entries apply oldest first, then the delay-0 request; survivors compact toward slot 0.
    always_comb begin
        int k;
        k = 0;
        for (int w = 0; w < DEPTH; w++) mem_nxt[w] = mem[w];
        for (int i = 0; i < QDEPTH; i++) begin
            q_vld_nxt[i]  = 1'b0;
            q_cnt_nxt[i]  = '0;
            q_word_nxt[i] = '0;
            q_lane_nxt[i] = '0;
            q_full_nxt[i] = 1'b0;
            q_data_nxt[i] = '0;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (q_vld[i]) begin
                if (q_cnt[i] == DW'(1)) begin
                    mem_nxt[q_word[i]] = merge(mem_nxt[q_word[i]], q_full[i], q_lane[i], q_data[i]);
                end else begin
                    q_vld_nxt[k]  = 1'b1;
                    q_cnt_nxt[k]  = q_cnt[i] - DW'(1);
                    q_word_nxt[k] = q_word[i];
                    q_lane_nxt[k] = q_lane[i];
                    q_full_nxt[k] = q_full[i];
                    q_data_nxt[k] = q_data[i];
                    k = k + 1;
                end
            end
        end
        if (accept && !drop) begin
            if (wr_delay == '0) begin
                mem_nxt[wr_word] = merge(mem_nxt[wr_word], wr_full, wr_lane, wr_data);
            end else begin
                q_vld_nxt[k]  = 1'b1;
                q_cnt_nxt[k]  = wr_delay;
                q_word_nxt[k] = wr_word;
                q_lane_nxt[k] = wr_lane;
                q_full_nxt[k] = wr_full;
                q_data_nxt[k] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_vld[i]  <= 1'b0;
                q_cnt[i]  <= '0;
                q_word[i] <= '0;
                q_lane[i] <= '0;
                q_full[i] <= 1'b0;
                q_data[i] <= '0;
            end
            wr_err <= 1'b0;
        end else begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= mem_nxt[w];
            for (int i = 0; i < QDEPTH; i++) begin
                q_vld[i]  <= q_vld_nxt[i];
                q_cnt[i]  <= q_cnt_nxt[i];
                q_word[i] <= q_word_nxt[i];
                q_lane[i] <= q_lane_nxt[i];
                q_full[i] <= q_full_nxt[i];
                q_data[i] <= q_data_nxt[i];
            end
            wr_err <= drop;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_word} < (AW+1)'(DEPTH)) rd_data = mem[rd_word];
    end

endmodule

// File: tb/tb_array_lane_write_sched.sv
// Bench for array_lane_write_sched: directed scenarios then random traffic against a
// model that tracks each queued write by the absolute edge at which it is due.
module tb_array_lane_write_sched;

    // DEPTH and MAX_DLY below the index/delay field ranges so out-of-range drops are reachable.
    localparam int WORD_W  = 8;
    localparam int DEPTH   = 6;
    localparam int LANE_W  = 4;
    localparam int MAX_DLY = 12;
    localparam int QDEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_word;
    logic [0:0] wr_lane;
    logic       wr_full;
    logic [7:0] wr_data;
    logic [3:0] wr_delay;
    logic [2:0] rd_word;
    logic [7:0] rd_data;
    logic [2:0] pending;
    logic       wr_err;

    array_lane_write_sched #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .LANE_W(LANE_W), .MAX_DLY(MAX_DLY), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_word(wr_word), .wr_lane(wr_lane), .wr_full(wr_full), .wr_data(wr_data),
        .wr_delay(wr_delay), .rd_word(rd_word), .rd_data(rd_data),
        .pending(pending), .wr_err(wr_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        int       due;
        int       word;
        bit       full;
        int       lane;
        bit [7:0] data;
    } ent_t;

    ent_t     mq[$];
    bit [7:0] m [DEPTH];
    bit       err_m;
    int       edge_n;
    int       n_chk;
    int       n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic void apply(int w, bit full, int lane, bit [7:0] d);
        if (full) m[w] = d;
        else for (int b = 0; b < LANE_W; b++) m[w][lane*LANE_W + b] = d[b];
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int w = 0; w < DEPTH; w++) m[w] = 8'h00;
        err_m = 1'b0;
    endfunction

    task automatic check_state();
        chk("pending", pending, mq.size());
        chk("wr_err", wr_err, err_m);
        for (int w = 0; w < DEPTH; w++) begin
            rd_word = 3'(w);
            #1;
            chk($sformatf("rd_data[%0d]", w), rd_data, m[w]);
        end
    endtask

    // One clock: check ready, clock the DUT, advance the model, check outputs.
    task automatic cycle(output bit acc);
        bit drp;
        int i;
        chk("wr_ready", wr_ready, (mq.size() < QDEPTH));
        acc = wr_valid && (mq.size() < QDEPTH);
        drp = acc && (int'(wr_word) >= DEPTH || int'(wr_delay) > MAX_DLY);
        @(posedge clk);
        edge_n++;
        i = 0;
        while (i < mq.size()) begin
            if (mq[i].due == edge_n) begin
                apply(mq[i].word, mq[i].full, mq[i].lane, mq[i].data);
                mq.delete(i);
            end else i++;
        end
        if (acc && !drp) begin
            if (wr_delay == 4'd0) apply(wr_word, wr_full, wr_lane, wr_data);
            else mq.push_back('{due: edge_n + int'(wr_delay), word: int'(wr_word),
                                full: wr_full, lane: int'(wr_lane), data: wr_data});
        end
        err_m = drp;
        #1;
        check_state();
    endtask

    task automatic req(input bit v, input int w, input int l, input bit f,
                       input bit [7:0] d, input int dl);
        bit acc;
        wr_valid = v;
        wr_word  = 3'(w);
        wr_lane  = 1'(l);
        wr_full  = f;
        wr_data  = d;
        wr_delay = 4'(dl);
        cycle(acc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        bit acc;
        int budget;
        n_chk = 0; n_fail = 0; edge_n = 0;
        model_reset();
        rst_n = 1'b0;
        wr_valid = 0; wr_word = 0; wr_lane = 0; wr_full = 0; wr_data = 0; wr_delay = 0; rd_word = 0;
        #15;
        check_state();
        rst_n = 1'b1;

        // lane write, immediate
        req(1, 1, 1, 0, 8'h0a, 0);
        chk("plan1_word1", m[1], 8'ha0);
        // full then lane on word 2; lane on fresh word 3
        req(1, 2, 0, 1, 8'hbc, 0);
        req(1, 2, 0, 0, 8'h0d, 0);
        req(1, 3, 0, 0, 8'h0d, 0);
        // delay 3 on word 5
        req(1, 5, 1, 0, 8'h04, 3);
        idle(3);
        // two writes maturing together on word 4
        req(1, 4, 0, 1, 8'h11, 2);
        req(1, 4, 0, 0, 8'h0f, 1);
        idle(2);
        req(1, 4, 0, 1, 8'h22, 2);
        idle(1);
        req(1, 4, 0, 0, 8'h0e, 0);
        idle(1);
        // fill the queue, then hold a delay-0 request until a slot frees
        for (int i = 0; i < QDEPTH; i++) req(1, i, 1, 0, 8'(i + 5), 10);
        wr_valid = 1; wr_word = 3'd0; wr_lane = 1'd0; wr_full = 1; wr_data = 8'h77; wr_delay = 4'd0;
        budget = 20;
        do begin
            cycle(acc);
            budget--;
        end while (!acc && budget > 0);
        if (!acc) chk("stall_timeout", 0, 1);
        idle(12);
        // drops: out-of-range word, out-of-range delay
        req(1, 6, 0, 1, 8'hff, 0);
        idle(1);
        req(1, 0, 0, 1, 8'hff, 13);
        idle(1);
        // reset with entries queued
        req(1, 1, 0, 1, 8'h55, 5);
        req(1, 2, 1, 0, 8'h06, 4);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_state();
        rst_n = 1'b1;
        idle(8);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int dl;
            dl = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            req(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 1), 8'($urandom), dl);
        end
        idle(16);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
